// File: rtl/friet_c_stream_buffer_out.sv
// rtl/friet_c_stream_buffer_out.sv - splits wide data blocks into narrow output words
//
// Purpose: accepts one DIN_WIDTH-bit block carrying 0..2**DIN_SIZE_WIDTH valid
// bytes and replays it as a sequence of DOUT_WIDTH-bit words, byte 0 first.
// The next block is accepted in the same cycle the final word is consumed, so
// consecutive blocks stream without idle cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   din           input block, byte 0 at bits [7:0]
//   din_size      valid bytes in din (values above the block size are clamped)
//   din_last      block ends the message
//   din_valid     input handshake (valid)
//   din_ready     input handshake (ready)
//   dout          output word, byte 0 at bits [7:0], unused bytes zeroed
//   dout_size     valid bytes in dout
//   dout_last     final word of the message
//   dout_valid    output handshake (valid)
//   dout_ready    output handshake (ready)
//   buffer_empty  no block currently held
module friet_c_stream_buffer_out #(
  parameter int DIN_WIDTH       = 128,
  parameter int DIN_SIZE_WIDTH  = 4,
  parameter int DOUT_WIDTH      = 32,
  parameter int DOUT_SIZE_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIN_WIDTH-1:0]       din,
  input  logic [DIN_SIZE_WIDTH:0]    din_size,
  input  logic                       din_last,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [DOUT_WIDTH-1:0]      dout,
  output logic [DOUT_SIZE_WIDTH:0]   dout_size,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       buffer_empty
);

  localparam int RW = DIN_SIZE_WIDTH + 1;
  localparam int SW = DOUT_SIZE_WIDTH + 1;
  localparam int OUT_BYTES = 1 << DOUT_SIZE_WIDTH;

  localparam logic [RW-1:0] MAX_IN_BYTES  = RW'(1 << DIN_SIZE_WIDTH);
  localparam logic [RW-1:0] OUT_BYTES_REM = RW'(OUT_BYTES);
  localparam logic [SW-1:0] OUT_BYTES_SZ  = SW'(OUT_BYTES);

  logic [DIN_WIDTH-1:0] data_q;
  logic [RW-1:0]        rem_q;
  logic                 last_q;
  logic                 active_q;

  logic                 final_word;
  logic                 din_fire;
  logic                 dout_fire;
  logic [RW-1:0]        in_size;

  // The word on dout is the last one of the held block when no more than one
  // word's worth of bytes remains.
  assign final_word = (rem_q <= OUT_BYTES_REM);

  // Only the final word frees the buffer, so a new block may be taken while
  // idle or in the very cycle the final word leaves.
  assign din_ready = ~rst & (~active_q | (dout_ready & final_word));
  assign din_fire  = din_valid & din_ready;
  assign dout_fire = active_q & dout_ready & ~rst;

  assign in_size = (din_size > MAX_IN_BYTES) ? MAX_IN_BYTES : din_size;

  assign dout_valid   = active_q;
  assign buffer_empty = ~active_q;
  assign dout_size    = final_word ? rem_q[SW-1:0] : OUT_BYTES_SZ;
  assign dout_last    = last_q & final_word;

  // Bytes beyond dout_size are zeroed so a short final word never exposes
  // stale or padding bytes of the block.
  for (genvar i = 0; i < OUT_BYTES; i++) begin : g_mask
    assign dout[i*8 +: 8] = (dout_size > SW'(i)) ? data_q[i*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (din_fire) begin
      // An empty non-final block carries nothing; drop it. An empty final
      // block still emits a single zero-size word to mark end of message.
      if ((in_size == '0) && !din_last) begin
        rem_q    <= '0;
        last_q   <= 1'b0;
        active_q <= 1'b0;
      end else begin
        data_q   <= din;
        rem_q    <= in_size;
        last_q   <= din_last;
        active_q <= 1'b1;
      end
    end else if (dout_fire) begin
      if (final_word) begin
        rem_q    <= '0;
        last_q   <= 1'b0;
        active_q <= 1'b0;
      end else begin
        data_q <= data_q >> DOUT_WIDTH;
        rem_q  <= rem_q - OUT_BYTES_REM;
      end
    end
  end

endmodule

// File: tb/tb_friet_c_stream_buffer_out.sv
// tb/tb_friet_c_stream_buffer_out.sv - directed vector bench for friet_c_stream_buffer_out
module tb_friet_c_stream_buffer_out;

  localparam logic [127:0] BA = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BC = 128'h1f1e1d1c1b1a19181716151413121110;

  typedef struct {
    logic         rst;
    logic [127:0] din;
    logic [4:0]   size;
    logic         last;
    logic         valid;
    logic         ready;
    logic         ev;
    logic [31:0]  ed;
    logic [2:0]   es;
    logic         el;
    logic         edr;
    logic         ee;
    logic         cd;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic [4:0]   din_size;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [31:0]  dout;
  logic [2:0]   dout_size;
  logic         dout_last;
  logic         dout_valid;
  logic         dout_ready;
  logic         buffer_empty;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  friet_c_stream_buffer_out dut (
    .clk(clk), .rst(rst),
    .din(din), .din_size(din_size), .din_last(din_last),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_size(dout_size), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .buffer_empty(buffer_empty)
  );

  function automatic vec_t mk(input logic r, input logic [127:0] d, input logic [4:0] s,
                              input logic l, input logic v, input logic rd,
                              input logic ev, input logic [31:0] ed, input logic [2:0] es,
                              input logic el, input logic edr, input logic ee, input logic cd);
    vec_t t;
    t.rst = r; t.din = d; t.size = s; t.last = l; t.valid = v; t.ready = rd;
    t.ev = ev; t.ed = ed; t.es = es; t.el = el; t.edr = edr; t.ee = ee; t.cd = cd;
    return t;
  endfunction

  // Expected: held word of a streaming block, din_ready as given.
  function automatic vec_t wd(input logic v, input logic [127:0] d, input logic [4:0] s,
                              input logic l, input logic rd,
                              input logic [31:0] ed, input logic [2:0] es, input logic el,
                              input logic edr);
    return mk(1'b0, d, s, l, v, rd, 1'b1, ed, es, el, edr, 1'b0, 1'b1);
  endfunction

  // Expected: nothing held; word contents unconstrained.
  function automatic vec_t idl(input logic v, input logic [127:0] d, input logic [4:0] s,
                               input logic l);
    return mk(1'b0, d, s, l, v, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; din = t.din; din_size = t.size; din_last = t.last;
    din_valid = t.valid; dout_ready = t.ready;
    #1;
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(t.ev));
    check({tag, ".din_ready"}, 32'(din_ready), 32'(t.edr));
    check({tag, ".buffer_empty"}, 32'(buffer_empty), 32'(t.ee));
    if (t.cd) begin
      check({tag, ".dout"}, dout, t.ed);
      check({tag, ".dout_size"}, 32'(dout_size), 32'(t.es));
      check({tag, ".dout_last"}, 32'(dout_last), 32'(t.el));
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_size = '0; din_last = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    @(posedge clk);

    // reset: handshake offered but ignored, outputs idle
    tbl.push_back(mk(1, BA, 16, 1, 1, 1, 0, 32'h0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, BA, 16, 1, 0, 1, 0, 32'h0, 0, 0, 1, 1, 1));
    // full block, ready held high
    tbl.push_back(idl(1, BA, 16, 1));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h03020100, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h07060504, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0b0a0908, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0f0e0d0c, 4, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));
    // partial block of 6 bytes
    tbl.push_back(idl(1, BA, 6, 1));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h03020100, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h00000504, 2, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));
    // back-to-back blocks, second taken on the final word of the first
    tbl.push_back(idl(1, BA, 16, 0));
    tbl.push_back(wd(1, BC, 16, 1, 1, 32'h03020100, 4, 0, 0));
    tbl.push_back(wd(1, BC, 16, 1, 1, 32'h07060504, 4, 0, 0));
    tbl.push_back(wd(1, BC, 16, 1, 1, 32'h0b0a0908, 4, 0, 0));
    tbl.push_back(wd(1, BC, 16, 1, 1, 32'h0f0e0d0c, 4, 0, 1));
    tbl.push_back(wd(0, BC, 0, 0, 1, 32'h13121110, 4, 0, 0));
    tbl.push_back(wd(0, BC, 0, 0, 1, 32'h17161514, 4, 0, 0));
    tbl.push_back(wd(0, BC, 0, 0, 1, 32'h1b1a1918, 4, 0, 0));
    tbl.push_back(wd(0, BC, 0, 0, 1, 32'h1f1e1d1c, 4, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));
    // empty blocks: dropped when not last, one zero-size word when last
    tbl.push_back(idl(1, BA, 0, 0));
    tbl.push_back(idl(0, BA, 0, 0));
    tbl.push_back(idl(1, BA, 0, 1));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h00000000, 0, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));
    // oversize din_size clamps to a full block
    tbl.push_back(idl(1, BA, 20, 1));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h03020100, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h07060504, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0b0a0908, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0f0e0d0c, 4, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));
    // backpressure: ready toggles, words hold while ready is low
    tbl.push_back(idl(1, BA, 16, 1));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h03020100, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 0, 32'h07060504, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h07060504, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 0, 32'h0b0a0908, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0b0a0908, 4, 0, 0));
    tbl.push_back(wd(0, BA, 0, 0, 0, 32'h0f0e0d0c, 4, 1, 0));
    tbl.push_back(wd(0, BA, 0, 0, 1, 32'h0f0e0d0c, 4, 1, 1));
    tbl.push_back(idl(0, BA, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], $sformatf("row%0d", i));
    end

    // reset during the third word of a block, then a fresh 6-byte block
    run(idl(1, BA, 16, 1), "rs0");
    run(wd(0, BA, 0, 0, 1, 32'h03020100, 4, 0, 0), "rs1");
    run(wd(0, BA, 0, 0, 1, 32'h07060504, 4, 0, 0), "rs2");
    run(mk(1, BC, 6, 1, 1, 1, 1, 32'h0b0a0908, 4, 0, 0, 0, 1), "rs3");
    run(mk(0, BC, 6, 1, 0, 1, 0, 32'h0, 0, 0, 1, 1, 1), "rs4");
    run(mk(0, BC, 6, 1, 1, 1, 0, 32'h0, 0, 0, 1, 1, 1), "rs5");
    run(wd(0, BC, 0, 0, 1, 32'h13121110, 4, 0, 0), "rs6");
    run(wd(0, BC, 0, 0, 1, 32'h00001514, 2, 1, 1), "rs7");
    run(idl(0, BA, 0, 0), "rs8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
